// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/param_cosa_sub.sv
// Exact carry-skip subtractor: diff = a - b, no_borrow = carry-out of a + ~b + 1.
module param_cosa_sub #(
    parameter int N   = 9,
    parameter int BLK = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         no_borrow
);

    localparam int NB = (N + BLK - 1) / BLK;

    logic [N-1:0] b_n;
    logic [N-1:0] p;

    assign b_n = ~b;
    assign p   = a ^ b_n;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        localparam int LO = k * BLK;
        localparam int HI = ((k + 1) * BLK < N) ? (k + 1) * BLK - 1 : N - 1;
        localparam int BW = HI - LO + 1;

        logic ci;
        logic co;

        if (k == 0) begin : g_cin0
            assign ci = 1'b1;
        end else begin : g_cink
            assign ci = g_blk[k-1].co;
        end

        for (genvar j = 0; j < BW; j++) begin : g_bit
            logic c_in;
            logic c_out;

            if (j == 0) begin : g_first
                assign c_in = ci;
            end else begin : g_rest
                assign c_in = g_bit[j-1].c_out;
            end

            param_full_adder #(
                .APPROX (1'b0)
            ) u_fa (
                .a    (a[LO+j]),
                .b    (b_n[LO+j]),
                .cin  (c_in),
                .s    (diff[LO+j]),
                .cout (c_out)
            );
        end

        // A fully propagating block passes its carry-in straight through.
        assign co = (&p[HI:LO]) ? ci : g_bit[BW-1].c_out;
    end

    assign no_borrow = g_blk[NB-1].co;

endmodule

// File: rtl/param_full_adder.sv
// One-bit full adder; APPROX=1 selects the carry-free approximate cell.
module param_full_adder #(
    parameter bit APPROX = 1'b0
) (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    if (APPROX) begin : g_approx
        assign s    = a | b | cin;
        assign cout = a & b;
    end else begin : g_exact
        assign s    = a ^ b ^ cin;
        assign cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/param_seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock,
// with valid/ready handshakes on operands and result.
module param_seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e state_q, state_d;

    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             start_ready_q, start_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic             take;

    assign r_sh = {r_q, q_q[WIDTH-1]};

    param_cosa_sub #(
        .N (WIDTH + 1)
    ) u_sub (
        .a         (r_sh),
        .b         ({1'b0, dvsr_q}),
        .diff      (trial),
        .no_borrow (no_borrow)
    );

    // R < divisor keeps r_sh < 2*divisor, so a kept trial always fits WIDTH bits.
    assign take = no_borrow & ~trial[WIDTH];

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    dvsr_d  = divisor;
                    q_d     = dividend;
                    r_d     = '0;
                    cnt_d   = (divisor == '0) ? CNT_W'(1) : CNT_W'(WIDTH);
                    state_d = CALC;
                end
            end
            CALC: begin
                r_d   = take ? trial[WIDTH-1:0] : r_sh[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], take};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    // Zero divisor spends a single cycle; Q still holds the dividend.
                    if (dvsr_q == '0) begin
                        quo_d = DIV0_QUOTIENT[WIDTH-1:0];
                        rem_d = q_q;
                        dbz_d = 1'b1;
                    end else begin
                        quo_d = q_d;
                        rem_d = r_d;
                        dbz_d = 1'b0;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        start_ready_d = (state_d == IDLE);
        out_valid_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            r_q           <= '0;
            q_q           <= '0;
            dvsr_q        <= '0;
            cnt_q         <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            dbz_q         <= 1'b0;
            start_ready_q <= 1'b1;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            q_q           <= q_d;
            dvsr_q        <= dvsr_d;
            cnt_q         <= cnt_d;
            quo_q         <= quo_d;
            rem_q         <= rem_d;
            dbz_q         <= dbz_d;
            start_ready_q <= start_ready_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign start_ready = start_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_param_seq_divider.sv
// Self-checking bench for param_seq_divider against an arithmetic reference model.
module tb_param_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    param_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? 255 : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    // Drives one transaction; lat = edges from accept to out_valid (100 = timeout).
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output bit sr_seen, output bit busy_lo);
        int g = 0;
        dividend    = a;
        divisor     = b;
        start_valid = 1'b1;
        while (!start_ready && g < 100) begin
            @(posedge clk); #1; g++;
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        dividend    = W'($urandom);
        divisor     = W'($urandom);
        lat     = 0;
        sr_seen = 1'b0;
        busy_lo = 1'b0;
        while (!out_valid && lat < 100) begin
            if (start_ready) sr_seen = 1'b1;
            if (!busy) busy_lo = 1'b1;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({start_ready, out_valid, div_by_zero, busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 1000",
                     {start_ready, out_valid, div_by_zero, busy});
        end
        n_checks++;
        if (quotient !== 8'd0 || remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_result: got %0d r%0d expected 0 r0", quotient, remainder);
        end
    endtask

    task automatic test_basic();
        int lat; bit sr; bit bl;
        out_ready = 1'b1;
        run(8'd100, 8'd7, lat, sr, bl);
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 8", lat);
        end
        n_checks++;
        if (quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got %0d r%0d z%b expected 14 r2 z0",
                     quotient, remainder, div_by_zero);
        end
        n_checks++;
        if (sr !== 1'b0 || bl !== 1'b0 || start_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: got sr_seen=%b busy_lo=%b expected 0 0", sr, bl);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_return: got ov=%b sr=%b busy=%b expected 0 1 0",
                     out_valid, start_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        bit sr = 1'b0;
        out_ready   = 1'b1;
        dividend    = 8'd255;
        divisor     = 8'd1;
        start_valid = 1'b1;
        @(posedge clk); #1;
        dividend = 8'd5;
        divisor  = 8'd9;
        while (!out_valid && lat < 100) begin
            if (start_ready) sr = 1'b1;
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (lat !== 8 || quotient !== 8'd255 || remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL b2b_first: got lat=%0d %0d r%0d expected 8 255 r0",
                     lat, quotient, remainder);
        end
        n_checks++;
        if (sr !== 1'b0 || start_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready: got sr_seen=%b sr=%b expected 0 0", sr, start_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (start_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got sr=%b ov=%b expected 1 0", start_ready, out_valid);
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (lat !== 8 || quotient !== 8'd0 || remainder !== 8'd5) begin
            n_fail++;
            $display("FAIL b2b_second: got lat=%0d %0d r%0d expected 8 0 r5",
                     lat, quotient, remainder);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        int lat; bit sr; bit bl;
        out_ready = 1'b1;
        run(8'd37, 8'd0, lat, sr, bl);
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL dz_latency: got %0d expected 1", lat);
        end
        n_checks++;
        if (quotient !== 8'd255 || remainder !== 8'd37 || div_by_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL dz_result: got %0d r%0d z%b expected 255 r37 z1",
                     quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        n_checks++;
        if (div_by_zero !== 1'b0 || quotient !== 8'd255 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dz_clear: got z%b q%0d ov%b expected z0 q255 ov0",
                     div_by_zero, quotient, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat; bit sr; bit bl;
        int bad = 0;
        out_ready = 1'b0;
        run(8'd200, 8'd13, lat, sr, bl);
        n_checks++;
        if (lat !== 8 || quotient !== 8'd15 || remainder !== 8'd5) begin
            n_fail++;
            $display("FAIL bp_result: got lat=%0d %0d r%0d expected 8 15 r5",
                     lat, quotient, remainder);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || start_ready !== 1'b0 ||
                quotient !== 8'd15 || remainder !== 8'd5) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0 ||
            remainder !== 8'd5) begin
            n_fail++;
            $display("FAIL bp_release: got ov=%b sr=%b busy=%b r%0d expected 0 1 0 r5",
                     out_valid, start_ready, busy, remainder);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit sr; bit bl;
        out_ready   = 1'b1;
        dividend    = 8'd128;
        divisor     = 8'd3;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({start_ready, out_valid, div_by_zero, busy} !== 4'b1000 ||
            quotient !== 8'd0 || remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_state: got flags=%b %0d r%0d expected 1000 0 r0",
                     {start_ready, out_valid, div_by_zero, busy}, quotient, remainder);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(8'd9, 8'd3, lat, sr, bl);
        n_checks++;
        if (lat !== 8 || quotient !== 8'd3 || remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_next: got lat=%0d %0d r%0d expected 8 3 r0",
                     lat, quotient, remainder);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat; bit sr; bit bl;
        int a; int b;
        for (int i = 0; i < 2000; i++) begin
            a = (i < 4) ? 0 : int'($urandom_range(0, 255));
            b = (i % 50 == 1) ? 255 : int'($urandom_range(1, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            run(W'(a), W'(b), lat, sr, bl);
            n_checks++;
            if (lat !== 8 || int'(quotient) !== ref_q(a, b) ||
                int'(remainder) !== ref_r(a, b) || div_by_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_model: %0d/%0d got lat=%0d %0d r%0d expected 8 %0d r%0d",
                         a, b, lat, quotient, remainder, ref_q(a, b), ref_r(a, b));
            end
            n_checks++;
            if (int'(quotient) * b + int'(remainder) !== a || int'(remainder) >= b) begin
                n_fail++;
                $display("FAIL rand_invariant: %0d/%0d got %0d r%0d", a, b,
                         quotient, remainder);
            end
            if (!out_ready) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
